// File: rtl/mac_dot_seq_if.sv
// Handshake bundle between the dot-product sequencer, its command/operand
// source, the external MAC and the result consumer.
interface mac_dot_seq_if #(
  parameter int LEN_W = 8,
  parameter int DW    = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic             in_ready;
  logic [DW-1:0]    mac_a;
  logic [DW-1:0]    mac_b;
  logic             mac_clr;
  logic [15:0]      mac_acc;
  logic             mac_cout;
  logic             res_valid;
  logic [15:0]      res_data;
  logic             res_ovf;
  logic             res_ready;

  modport master (
    output start, len, in_valid, in_a, in_b, mac_acc, mac_cout, res_ready,
    input  busy, in_ready, mac_a, mac_b, mac_clr, res_valid, res_data, res_ovf
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, mac_acc, mac_cout, res_ready,
    output busy, in_ready, mac_a, mac_b, mac_clr, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/mac_dot_seq.sv
// Sequencer feeding a free-running 8x8->16 MAC to compute one dot product per command.
// Build option: define MAC_SEQ_SAT_EN to saturate res_data to 16'hFFFF on overflow.
module mac_dot_seq #(
  parameter int LEN_W = 8,
  parameter int DW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  mac_dot_seq_if.slave bus
);

`ifdef MAC_SEQ_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      res_data_q, res_data_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_valid_q, res_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             clr_q, clr_d;
  logic             xfer;
  logic             ovf_now;
  logic [DW-1:0]    a_sel, b_sel;

  function automatic logic [15:0] fmt_result(input logic [15:0] acc, input logic ovf);
    return (SAT_EN && ovf) ? 16'hFFFF : acc;
  endfunction

  assign xfer    = bus.in_valid & in_ready_q;
  assign ovf_now = ovf_q | bus.mac_cout;

  // The MAC adds every clock, so it must see zero operands whenever no pair moves.
  assign a_sel = xfer ? bus.in_a : '0;
  assign b_sel = xfer ? bus.in_b : '0;

  assign bus.mac_a     = a_sel;
  assign bus.mac_b     = b_sel;
  assign bus.mac_clr   = rst | clr_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d   = bus.len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        ovf_d   = 1'b0;
        state_d = (cnt_q != '0) ? RUN : DRAIN;
      end
      RUN: begin
        ovf_d = ovf_now;
        if (xfer) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Accumulator already holds the final sum; its carry still counts.
        ovf_d      = ovf_now;
        res_data_d = fmt_result(bus.mac_acc, ovf_now);
        res_ovf_d  = ovf_now;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == RUN);
    clr_d       = (state_d == CLEAR);
    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      clr_q       <= clr_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural 16-bit MAC attached to its
// operand/clear outputs; table of commands plus hand-written corner sequences.
module tb_mac_dot_seq;
  localparam int LEN_W = 8;
  localparam int DW    = 8;

  typedef struct packed {
    int             len;
    logic [7:0][7:0] a;
    logic [7:0][7:0] b;
    bit             gaps;
    logic [15:0]    exp_data;
    bit             exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mac_dot_seq_if #(.LEN_W(LEN_W), .DW(DW)) bus ();

  mac_dot_seq #(.LEN_W(LEN_W), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural MAC: registered acc/carry, synchronous clear from mac_clr.
  logic [15:0] mac_prod;
  logic [16:0] mac_sum;
  assign mac_prod = 16'(bus.mac_a) * 16'(bus.mac_b);
  assign mac_sum  = {1'b0, bus.mac_acc} + {1'b0, mac_prod};

  always @(posedge clk) begin
    if (bus.mac_clr) begin
      bus.mac_acc  <= 16'd0;
      bus.mac_cout <= 1'b0;
    end else begin
      bus.mac_acc  <= mac_sum[15:0];
      bus.mac_cout <= mac_sum[16];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] held;
    bus.len   = v.len[LEN_W-1:0];
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check({tag, " clear_pulse"}, bus.mac_clr, 1);
    check({tag, " busy_clear"}, bus.busy, 1);
    check({tag, " no_ready_in_clear"}, bus.in_ready, 0);
    step();
    check({tag, " first_ready"}, bus.in_ready, 1);
    for (int i = 0; i < v.len; i++) begin
      if (v.gaps && i > 0) begin
        held         = bus.mac_acc;
        bus.in_valid = 1'b0;
        bus.in_a     = 8'hAA;
        bus.in_b     = 8'h55;
        step();
        step();
        check({tag, " acc_hold_gap"}, bus.mac_acc, held);
        check({tag, " ready_in_gap"}, bus.in_ready, 1);
      end
      bus.in_valid = 1'b1;
      bus.in_a     = v.a[i];
      bus.in_b     = v.b[i];
      step();
    end
    bus.in_valid = 1'b0;
    check({tag, " ready_drop"}, bus.in_ready, 0);
    check({tag, " no_valid_in_drain"}, bus.res_valid, 0);
    step();
    check({tag, " res_valid"}, bus.res_valid, 1);
    check({tag, " res_data"}, bus.res_data, v.exp_data);
    check({tag, " res_ovf"}, bus.res_ovf, v.exp_ovf);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check({tag, " idle_busy"}, bus.busy, 0);
    check({tag, " idle_valid"}, bus.res_valid, 0);
  endtask

  vec_t vecs [5];
  vec_t v_one;

  initial begin
    vecs[0] = '{len: 4, a: {8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd5, 8'd3},
                b: {8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd3, 8'd1, 8'd2},
                gaps: 1'b0, exp_data: 16'd26, exp_ovf: 1'b0};
    vecs[1] = '{len: 6, a: {8'd0, 8'd0, 8'd22, 8'd255, 8'd3, 8'd2, 8'd5, 8'd3},
                b: {8'd0, 8'd0, 8'd12, 8'd255, 8'd3, 8'd3, 8'd1, 8'd2},
                gaps: 1'b1, exp_data: 16'd65315, exp_ovf: 1'b0};
`ifdef MAC_SEQ_SAT_EN
    vecs[2] = '{len: 2, a: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255},
                b: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255},
                gaps: 1'b0, exp_data: 16'd65535, exp_ovf: 1'b1};
`else
    vecs[2] = '{len: 2, a: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255},
                b: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255},
                gaps: 1'b0, exp_data: 16'd64514, exp_ovf: 1'b1};
`endif
    vecs[3] = '{len: 3, a: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd100},
                b: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd1, 8'd200},
                gaps: 1'b1, exp_data: 16'd20001, exp_ovf: 1'b0};
    vecs[4] = '{len: 8, a: 64'h1010_1010_1010_1010, b: 64'h1010_1010_1010_1010,
                gaps: 1'b0, exp_data: 16'd2048, exp_ovf: 1'b0};
    v_one   = '{len: 1, a: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7},
                b: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9},
                gaps: 1'b0, exp_data: 16'd63, exp_ovf: 1'b0};

    // Reset state, with junk on the operand inputs
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd5;
    bus.in_b      = 8'd7;
    bus.res_ready = 1'b0;
    step();
    step();
    check("rst busy", bus.busy, 0);
    check("rst in_ready", bus.in_ready, 0);
    check("rst res_valid", bus.res_valid, 0);
    check("rst res_data", bus.res_data, 0);
    check("rst res_ovf", bus.res_ovf, 0);
    check("rst mac_clr", bus.mac_clr, 1);
    check("rst mac_a", bus.mac_a, 0);
    check("rst mac_b", bus.mac_b, 0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("idle mac_clr", bus.mac_clr, 0);
    check("idle acc", bus.mac_acc, 0);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // len = 0: straight through to DONE, result held while consumer stalls
    bus.len   = '0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("len0 clear_pulse", bus.mac_clr, 1);
    step();
    check("len0 no_ready_drain", bus.in_ready, 0);
    check("len0 busy_drain", bus.busy, 1);
    step();
    check("len0 no_ready_done", bus.in_ready, 0);
    check("len0 res_ovf", bus.res_ovf, 0);
    for (int k = 0; k < 5; k++) begin
      check("len0 res_valid_hold", bus.res_valid, 1);
      check("len0 res_data_hold", bus.res_data, 0);
      step();
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("len0 idle_busy", bus.busy, 0);

    // Reset after two of four transfers, then a fresh single-pair command
    bus.len   = 8'd4;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd3;
    bus.in_b     = 8'd2;
    step();
    bus.in_a = 8'd5;
    bus.in_b = 8'd1;
    step();
    bus.in_a = 8'd2;
    bus.in_b = 8'd3;
    rst      = 1'b1;
    #1;
    check("abort mac_clr", bus.mac_clr, 1);
    check("abort busy", bus.busy, 0);
    check("abort in_ready", bus.in_ready, 0);
    check("abort mac_a", bus.mac_a, 0);
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("abort acc_cleared", bus.mac_acc, 0);
    check("abort no_result", bus.res_valid, 0);
    run_vec(v_one, "after_abort");

    // start pulses during RUN and DONE must be ignored
    bus.len   = 8'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd2;
    bus.in_b     = 8'd2;
    step();
    bus.in_valid = 1'b0;
    bus.start    = 1'b1;
    bus.len      = 8'd5;
    step();
    bus.start = 1'b0;
    check("runstart in_ready", bus.in_ready, 1);
    check("runstart no_clear", bus.mac_clr, 0);
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd3;
    bus.in_b     = 8'd3;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd9;
    bus.in_b     = 8'd9;
    #1;
    check("done mac_a_zero", bus.mac_a, 0);
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("donestart res_valid", bus.res_valid, 1);
    check("donestart busy", bus.busy, 1);
    check("donestart res_data", bus.res_data, 13);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("donestart idle", bus.busy, 0);
    step();
    check("donestart not_queued", bus.busy, 0);
    check("donestart no_clear", bus.mac_clr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
